// File: rtl/result_unloader_pkg.sv
// rtl/result_unloader_pkg.sv - shared types and sizing helpers for the result unloader
package result_unloader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic int total_bits(input int cols, input int width);
      return cols * width;
   endfunction

   // Counter must be able to hold TOTAL itself, reached on the final transfer.
   function automatic int cnt_w(input int total);
      return $clog2(total + 1);
   endfunction

endpackage

// File: rtl/result_unloader_piso_shifter.sv
// rtl/result_unloader_piso_shifter.sv - parallel-load shadow register shifted toward its serial end
module piso_shifter #(
   parameter int WIDTH     = 53,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_i,
   output logic             ser_o
);

   logic [WIDTH-1:0] shadow_q, shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (load_i) begin
         shadow_d = load_data_i;
      end else if (shift_i) begin
         shadow_d = LSB_FIRST ? (shadow_q >> 1) : (shadow_q << 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign ser_o = LSB_FIRST ? shadow_q[0] : shadow_q[WIDTH-1];

endmodule

// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - captures compressor columns and shifts them out serially with parity
module result_unloader
   import result_unloader_pkg::*;
#(
   parameter int NUM_COLS  = 53,
   parameter int COL_WIDTH = 1,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_COLS*COL_WIDTH-1:0] dst_flat,
   input  logic                          capture,
   output logic                          busy,
   output logic                          ser_data,
   output logic                          ser_valid,
   input  logic                          ser_ready,
   output logic                          ser_last,
   output logic                          done,
   output logic                          parity,
   output logic                          overrun
);

   localparam int TOTAL = total_bits(NUM_COLS, COL_WIDTH);
   localparam int CW    = cnt_w(TOTAL);
   localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_par_q, run_par_d;
   logic          parity_q, parity_d;
   logic          overrun_q, overrun_d;
   logic          in_shift, at_last, xfer, load, shadow_bit;

   assign in_shift = (state_q == SHIFT);
   assign at_last  = (cnt_q == LAST_IDX);
   assign xfer     = in_shift & ser_ready;
   assign load     = (state_q == IDLE) & capture;

   piso_shifter #(
      .WIDTH     (TOTAL),
      .LSB_FIRST (LSB_FIRST)
   ) u_piso (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load),
      .load_data_i (dst_flat),
      .shift_i     (xfer),
      .ser_o       (shadow_bit)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      run_par_d = run_par_q;
      parity_d  = parity_q;
      overrun_d = overrun_q;
      case (state_q)
         IDLE: begin
            if (capture) begin
               state_d   = SHIFT;
               cnt_d     = '0;
               run_par_d = 1'b0;
               overrun_d = 1'b0;
            end
         end
         SHIFT: begin
            if (capture) overrun_d = 1'b1;
            if (xfer) begin
               cnt_d     = cnt_q + 1'b1;
               run_par_d = run_par_q ^ shadow_bit;
               // Publish parity on entry to DONE so it is valid alongside the done pulse.
               if (at_last) begin
                  state_d  = DONE;
                  parity_d = run_par_q ^ shadow_bit;
               end
            end
         end
         DONE: begin
            if (capture) overrun_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         run_par_q <= 1'b0;
         parity_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         run_par_q <= run_par_d;
         parity_q  <= parity_d;
         overrun_q <= overrun_d;
      end
   end

   // Outputs decode straight from state so an async reset clears them immediately.
   assign busy      = in_shift;
   assign ser_valid = in_shift;
   assign ser_data  = in_shift & shadow_bit;
   assign ser_last  = in_shift & at_last;
   assign done      = (state_q == DONE);
   assign parity    = parity_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - randomized self-checking bench for result_unloader
module tb_result_unloader;

   localparam int TOTAL = 53;

   logic        clk;
   logic        rst_n;
   logic [52:0] dst [2];
   logic        cap [2];
   logic        rdy [2];
   logic        bsy [2];
   logic        so  [2];
   logic        vo  [2];
   logic        lo  [2];
   logic        don [2];
   logic        par [2];
   logic        ovr [2];

   int n_vec = 0;
   int n_err = 0;

   logic [52:0] got;
   int          n_xfer, vcyc, last_err, stall_err, drop_err;
   bit          first_v, done_seen, done_after, par_got, timed_out;
   bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   result_unloader #(.NUM_COLS(53), .COL_WIDTH(1), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .dst_flat(dst[0]), .capture(cap[0]), .busy(bsy[0]),
      .ser_data(so[0]), .ser_valid(vo[0]), .ser_ready(rdy[0]), .ser_last(lo[0]),
      .done(don[0]), .parity(par[0]), .overrun(ovr[0]));

   result_unloader #(.NUM_COLS(53), .COL_WIDTH(1), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst_n(rst_n), .dst_flat(dst[1]), .capture(cap[1]), .busy(bsy[1]),
      .ser_data(so[1]), .ser_valid(vo[1]), .ser_ready(rdy[1]), .ser_last(lo[1]),
      .done(don[1]), .parity(par[1]), .overrun(ovr[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the order in which the bits of d must appear on the wire.
   function automatic logic [52:0] wire_order(input logic [52:0] d, input bit lsb_first);
      logic [52:0] r;
      for (int i = 0; i < TOTAL; i++) r[i] = lsb_first ? d[i] : d[TOTAL-1-i];
      return r;
   endfunction

   function automatic bit model_parity(input logic [52:0] d);
      return bit'($countones(d) % 2);
   endfunction

   function automatic logic [52:0] rand53();
      return 53'({$urandom(), $urandom()});
   endfunction

   // Drives one frame from a negedge and records what the sink saw; ends on the IDLE negedge.
   // mode: 0 ready always, 1 repeating 1,0,0,1, 2 random ready.
   task automatic run_frame(input int u, input logic [52:0] d, input int mode,
                            input int cap_at, input bit cap_in_done);
      bit r, prev_stall, prev_bit, fin;
      int ph;
      got = '0; n_xfer = 0; vcyc = 0; last_err = 0; stall_err = 0; drop_err = 0;
      done_seen = 0; done_after = 0; par_got = 0; timed_out = 0; fin = 0;
      prev_stall = 0; prev_bit = 0; ph = 0;
      dst[u] = d; cap[u] = 1'b1; rdy[u] = 1'b0;
      @(negedge clk);
      cap[u] = 1'b0;
      first_v = vo[u];
      for (int c = 0; c < 600; c++) begin
         if (vo[u]) begin
            if (prev_stall && so[u] !== prev_bit) stall_err++;
            cap[u] = (vcyc == cap_at);
            if (vcyc == cap_at) dst[u] = ~d;
            if (lo[u] !== (n_xfer == TOTAL - 1)) last_err++;
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = pat[ph % 4];
            else r = 1'($urandom_range(0, 1));
            ph++;
            rdy[u] = r;
            if (r) begin
               if (n_xfer < TOTAL) got[n_xfer] = so[u];
               n_xfer++;
            end
            prev_stall = !r; prev_bit = so[u]; vcyc++;
         end else begin
            cap[u] = 1'b0; rdy[u] = 1'b0;
            if (n_xfer == TOTAL) begin
               done_seen = don[u]; par_got = par[u];
               cap[u] = cap_in_done;
               @(negedge clk);
               cap[u] = 1'b0;
               done_after = don[u];
            end else begin
               drop_err++;
            end
            fin = 1;
            break;
         end
         @(negedge clk);
      end
      if (!fin) timed_out = 1;
      cap[u] = 1'b0; rdy[u] = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         cap[u] = 1'b0; rdy[u] = 1'b0; dst[u] = '0;
      end
      @(negedge clk); @(negedge clk);
      n_vec++; if ({bsy[0], vo[0], so[0], lo[0], don[0], par[0], ovr[0]} !== 7'b0) begin
         n_err++; $display("FAIL reset_lsb outs=%b exp=0000000", {bsy[0], vo[0], so[0], lo[0], don[0], par[0], ovr[0]});
      end
      n_vec++; if ({bsy[1], vo[1], so[1], lo[1], don[1], par[1], ovr[1]} !== 7'b0) begin
         n_err++; $display("FAIL reset_msb outs=%b exp=0000000", {bsy[1], vo[1], so[1], lo[1], don[1], par[1], ovr[1]});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (bsy[0] !== 1'b0 || don[0] !== 1'b0) begin
         n_err++; $display("FAIL post_reset_idle busy=%b done=%b exp=0 0", bsy[0], don[0]);
      end
   endtask

   task automatic test_basic;
      logic [52:0] d = 53'h1F_0000_0000_00A5;
      run_frame(0, d, 0, -1, 0);
      n_vec++; if (timed_out || drop_err != 0) begin n_err++; $display("FAIL basic_term timeout=%0d drop=%0d exp=0 0", timed_out, drop_err); end
      n_vec++; if (first_v !== 1'b1) begin n_err++; $display("FAIL basic_latency valid=%b exp=1", first_v); end
      n_vec++; if (got !== wire_order(d, 1)) begin n_err++; $display("FAIL basic_bits got=%h exp=%h", got, wire_order(d, 1)); end
      n_vec++; if (vcyc != TOTAL) begin n_err++; $display("FAIL basic_valid_cycles got=%0d exp=%0d", vcyc, TOTAL); end
      n_vec++; if (last_err != 0) begin n_err++; $display("FAIL basic_last errors=%0d exp=0", last_err); end
      n_vec++; if (done_seen !== 1'b1 || done_after !== 1'b0) begin n_err++; $display("FAIL basic_done pulse=%b,%b exp=1,0", done_seen, done_after); end
      n_vec++; if (par_got !== model_parity(d)) begin n_err++; $display("FAIL basic_parity got=%b exp=%b", par_got, model_parity(d)); end
   endtask

   task automatic test_backpressure;
      logic [52:0] d;
      for (int k = 0; k < 3; k++) begin
         d = (k == 0) ? 53'h1F_0000_0000_00A5 : rand53();
         run_frame(0, d, (k == 0) ? 1 : 2, -1, 0);
         n_vec++; if (got !== wire_order(d, 1) || n_xfer != TOTAL || timed_out) begin
            n_err++; $display("FAIL bp_bits[%0d] got=%h xfers=%0d exp=%h %0d", k, got, n_xfer, wire_order(d, 1), TOTAL);
         end
         n_vec++; if (stall_err != 0 || drop_err != 0) begin
            n_err++; $display("FAIL bp_stable[%0d] stall=%0d drop=%0d exp=0 0", k, stall_err, drop_err);
         end
         n_vec++; if (done_seen !== 1'b1 || par_got !== model_parity(d) || last_err != 0) begin
            n_err++; $display("FAIL bp_done[%0d] done=%b par=%b last_err=%0d exp=1 %b 0", k, done_seen, par_got, last_err, model_parity(d));
         end
      end
   endtask

   task automatic test_overrun;
      logic [52:0] d = rand53();
      run_frame(0, d, 0, 10, 0);
      n_vec++; if (ovr[0] !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", ovr[0]); end
      n_vec++; if (got !== wire_order(d, 1) || vcyc != TOTAL) begin
         n_err++; $display("FAIL ovr_frame got=%h cycles=%0d exp=%h %0d", got, vcyc, wire_order(d, 1), TOTAL);
      end
      d = rand53();
      run_frame(0, d, 0, -1, 0);
      n_vec++; if (ovr[0] !== 1'b0) begin n_err++; $display("FAIL ovr_clear got=%b exp=0", ovr[0]); end
      run_frame(0, d, 0, -1, 1);
      n_vec++; if (ovr[0] !== 1'b1 || bsy[0] !== 1'b0) begin
         n_err++; $display("FAIL ovr_in_done ovr=%b busy=%b exp=1 0", ovr[0], bsy[0]);
      end
   endtask

   task automatic test_reset_midframe;
      logic [52:0] d = rand53();
      int k = 0;
      bit hit = 0;
      dst[0] = d; cap[0] = 1'b1;
      @(negedge clk);
      cap[0] = 1'b0; rdy[0] = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (k == 20) begin hit = 1; break; end
         cap[0] = (k == 10);
         if (vo[0]) k++;
         @(negedge clk);
      end
      cap[0] = 1'b0;
      n_vec++; if (!hit || ovr[0] !== 1'b1) begin n_err++; $display("FAIL rst_pre reached=%0d ovr=%b exp=1 1", hit, ovr[0]); end
      rst_n = 1'b0;
      #1;
      n_vec++; if ({bsy[0], vo[0], don[0], ovr[0], lo[0], so[0]} !== 6'b0) begin
         n_err++; $display("FAIL rst_async outs=%b exp=000000", {bsy[0], vo[0], don[0], ovr[0], lo[0], so[0]});
      end
      @(negedge clk);
      rst_n = 1'b1; rdy[0] = 1'b0;
      @(negedge clk);
      n_vec++; if (don[0] !== 1'b0 || bsy[0] !== 1'b0) begin n_err++; $display("FAIL rst_no_done done=%b busy=%b exp=0 0", don[0], bsy[0]); end
      d = rand53();
      run_frame(0, d, 0, -1, 0);
      n_vec++; if (got !== wire_order(d, 1) || first_v !== 1'b1 || done_seen !== 1'b1 || par_got !== model_parity(d)) begin
         n_err++; $display("FAIL rst_restart got=%h v=%b done=%b par=%b exp=%h 1 1 %b", got, first_v, done_seen, par_got, wire_order(d, 1), model_parity(d));
      end
   endtask

   task automatic test_msb_first;
      logic [52:0] d = {1'b0, {52{1'b1}}};
      for (int k = 0; k < 2; k++) begin
         run_frame(1, d, (k == 0) ? 0 : 2, -1, 0);
         n_vec++; if (got !== wire_order(d, 0) || timed_out) begin
            n_err++; $display("FAIL msb_bits[%0d] got=%h exp=%h", k, got, wire_order(d, 0));
         end
         n_vec++; if (par_got !== model_parity(d) || done_seen !== 1'b1 || last_err != 0) begin
            n_err++; $display("FAIL msb_done[%0d] par=%b done=%b last_err=%0d exp=%b 1 0", k, par_got, done_seen, last_err, model_parity(d));
         end
         d = rand53();
      end
   endtask

   task automatic test_back_to_back;
      logic [52:0] d;
      for (int k = 0; k < 4; k++) begin
         d = rand53();
         run_frame(0, d, 0, -1, 0);
         n_vec++; if (first_v !== 1'b1 || got !== wire_order(d, 1) || vcyc != TOTAL) begin
            n_err++; $display("FAIL b2b_frame[%0d] v=%b got=%h cycles=%0d exp=1 %h %0d", k, first_v, got, vcyc, wire_order(d, 1), TOTAL);
         end
         n_vec++; if (done_seen !== 1'b1 || done_after !== 1'b0 || ovr[0] !== 1'b0 || par_got !== model_parity(d)) begin
            n_err++; $display("FAIL b2b_done[%0d] done=%b,%b ovr=%b par=%b exp=1,0 0 %b", k, done_seen, done_after, ovr[0], par_got, model_parity(d));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overrun();
      test_reset_midframe();
      test_msb_first();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
